ajuste_contador: RTL and testbench

- Bounded up/down value register driven by the debounced active-low step pulses from the button conditioners (`aumentar`/`disminuir` stages).
- Sits directly downstream of those conditioners.
- Holds the user-adjusted setpoint, e.g. a time or threshold digit pair, and feeds display and compare logic.
- Supports wrap-around or saturation at the limits, a parallel load, and limit flags.

---
 rtl/ajuste_pkg.sv | 31 +++
 rtl/ajuste_contador_flanco.sv | 30 +++
 rtl/ajuste_contador.sv | 129 ++++++++++++
 tb/tb_ajuste_contador.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ajuste_pkg.sv
// Shared constants, limit-mode enum and clamp helper for the ajuste_contador block.
package ajuste_pkg;

    localparam int unsigned ANCHO_DEF  = 7;
    localparam int unsigned MINIMO_DEF = 0;
    localparam int unsigned MAXIMO_DEF = 99;

    // Behaviour at the limits: wrap to the opposite limit or stick at the limit.
    typedef enum logic {
        MODO_SATURAR  = 1'b0,
        MODO_ENVOLVER = 1'b1
    } modo_limite_t;

    // Force a candidate value into [mn, mx]; operands are zero-extended, unsigned.
    function automatic logic [31:0] clamp_valor(
        input logic [31:0] v,
        input logic [31:0] mn,
        input logic [31:0] mx
    );
        logic [31:0] r;
        if (v < mn) begin
            r = mn;
        end else if (v > mx) begin
            r = mx;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/ajuste_contador_flanco.sv
// Falling-edge detector for an active-low, idle-high step input.
// The previous-sample flop tracks the raw input every cycle, so a held-low
// input yields a single one-cycle detection.
module detector_flanco_bajo (
    input  logic clk,
    input  logic reset_n,
    input  logic entrada,
    output logic flanco
);

    logic prev_d;
    logic prev_q;

    // Next previous-sample value is always the raw input.
    always_comb begin
        prev_d = entrada;
    end

    // Previous-sample register; idles high so no spurious edge after reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign flanco = (entrada == 1'b0) && (prev_q == 1'b1);

endmodule

// File: rtl/ajuste_contador.sv
// Bounded up/down setpoint register fed by debounced active-low step pulses.
// Supports wrap or saturation at the limits, a clamped parallel load and limit flags.
// Optional macro AJUSTE_CONTADOR_BCD_EN adds registered decimal digit outputs
// (decenas/unidades) that trail valor by one cycle.
module ajuste_contador
    import ajuste_pkg::*;
#(
    parameter int unsigned ANCHO    = ANCHO_DEF,
    parameter int unsigned MINIMO   = MINIMO_DEF,
    parameter int unsigned MAXIMO   = MAXIMO_DEF,
    parameter int unsigned INICIAL  = 0,
    parameter int unsigned ENVOLVER = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             habilitar,
    input  logic             aumentar,
    input  logic             disminuir,
    input  logic             cargar,
    input  logic [ANCHO-1:0] valor_carga,
    output logic [ANCHO-1:0] valor,
    output logic             en_max,
    output logic             en_min,
    output logic             cambio
`ifdef AJUSTE_CONTADOR_BCD_EN
    ,
    output logic [3:0]       decenas,
    output logic [3:0]       unidades
`endif
);

    localparam logic [ANCHO-1:0] MIN_V = ANCHO'(MINIMO);
    localparam logic [ANCHO-1:0] MAX_V = ANCHO'(MAXIMO);
    localparam logic [ANCHO-1:0] INI_V = ANCHO'(INICIAL);
    localparam modo_limite_t     MODO  = (ENVOLVER != 0) ? MODO_ENVOLVER : MODO_SATURAR;

    logic             step_up_s;
    logic             step_dn_s;
    logic [ANCHO-1:0] valor_d;
    logic [ANCHO-1:0] valor_q;
    logic             cambio_d;
    logic             cambio_q;

    detector_flanco_bajo u_flanco_aum (
        .clk     (clk),
        .reset_n (reset_n),
        .entrada (aumentar),
        .flanco  (step_up_s)
    );

    detector_flanco_bajo u_flanco_dis (
        .clk     (clk),
        .reset_n (reset_n),
        .entrada (disminuir),
        .flanco  (step_dn_s)
    );

    // Next value: load beats steps, simultaneous steps cancel, then up/down with limit handling.
    always_comb begin
        valor_d = valor_q;
        if (cargar) begin
            valor_d = ANCHO'(clamp_valor(32'(valor_carga), MINIMO, MAXIMO));
        end else if (habilitar && step_up_s && step_dn_s) begin
            valor_d = valor_q;
        end else if (habilitar && step_up_s) begin
            if (valor_q == MAX_V) begin
                valor_d = (MODO == MODO_ENVOLVER) ? MIN_V : MAX_V;
            end else begin
                valor_d = valor_q + ANCHO'(1);
            end
        end else if (habilitar && step_dn_s) begin
            if (valor_q == MIN_V) begin
                valor_d = (MODO == MODO_ENVOLVER) ? MAX_V : MIN_V;
            end else begin
                valor_d = valor_q - ANCHO'(1);
            end
        end else begin
            valor_d = valor_q;
        end
        cambio_d = (valor_d != valor_q);
    end

    // Value and change-strobe registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valor_q  <= INI_V;
            cambio_q <= 1'b0;
        end else begin
            valor_q  <= valor_d;
            cambio_q <= cambio_d;
        end
    end

    assign valor  = valor_q;
    assign cambio = cambio_q;
    assign en_max = (valor_q == MAX_V);
    assign en_min = (valor_q == MIN_V);

`ifdef AJUSTE_CONTADOR_BCD_EN
    localparam logic [3:0] DEC_INI = 4'(INICIAL / 10);
    localparam logic [3:0] UNI_INI = 4'(INICIAL % 10);

    logic [3:0] decenas_d;
    logic [3:0] decenas_q;
    logic [3:0] unidades_d;
    logic [3:0] unidades_q;

    // Decimal split of the current value (value never exceeds 99).
    always_comb begin
        decenas_d  = 4'(valor_q / ANCHO'(10));
        unidades_d = 4'(valor_q % ANCHO'(10));
    end

    // Digit registers, one cycle behind valor.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            decenas_q  <= DEC_INI;
            unidades_q <= UNI_INI;
        end else begin
            decenas_q  <= decenas_d;
            unidades_q <= unidades_d;
        end
    end

    assign decenas  = decenas_q;
    assign unidades = unidades_q;
`endif

endmodule

// File: tb/tb_ajuste_contador.sv
// Directed self-checking bench for ajuste_contador: one wrapping and one
// saturating instance share the same stimulus.
module tb_ajuste_contador;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       habilitar;
    logic       aumentar;
    logic       disminuir;
    logic       cargar;
    logic [6:0] valor_carga;

    logic [6:0] valor_w;
    logic       en_max_w;
    logic       en_min_w;
    logic       cambio_w;
    logic [6:0] valor_s;
    logic       en_max_s;
    logic       en_min_s;
    logic       cambio_s;
`ifdef AJUSTE_CONTADOR_BCD_EN
    logic [3:0] decenas_w;
    logic [3:0] unidades_w;
    logic [3:0] decenas_s;
    logic [3:0] unidades_s;
`endif

    int checks   = 0;
    int failures = 0;

    ajuste_contador #(.ANCHO(7), .MINIMO(0), .MAXIMO(99), .INICIAL(0), .ENVOLVER(1)) dut_w (
        .clk         (clk),
        .reset_n     (reset_n),
        .habilitar   (habilitar),
        .aumentar    (aumentar),
        .disminuir   (disminuir),
        .cargar      (cargar),
        .valor_carga (valor_carga),
        .valor       (valor_w),
        .en_max      (en_max_w),
        .en_min      (en_min_w),
        .cambio      (cambio_w)
`ifdef AJUSTE_CONTADOR_BCD_EN
        ,
        .decenas     (decenas_w),
        .unidades    (unidades_w)
`endif
    );

    ajuste_contador #(.ANCHO(7), .MINIMO(0), .MAXIMO(99), .INICIAL(0), .ENVOLVER(0)) dut_s (
        .clk         (clk),
        .reset_n     (reset_n),
        .habilitar   (habilitar),
        .aumentar    (aumentar),
        .disminuir   (disminuir),
        .cargar      (cargar),
        .valor_carga (valor_carga),
        .valor       (valor_s),
        .en_max      (en_max_s),
        .en_min      (en_min_s),
        .cambio      (cambio_s)
`ifdef AJUSTE_CONTADOR_BCD_EN
        ,
        .decenas     (decenas_s),
        .unidades    (unidades_s)
`endif
    );

    always #5 clk = ~clk;

    task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle past it.
    task automatic ciclo();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n     = 1'b0;
        habilitar   = 1'b1;
        aumentar    = 1'b1;
        disminuir   = 1'b1;
        cargar      = 1'b0;
        valor_carga = 7'd0;
        ciclo();
        ciclo();
        reset_n = 1'b1;
        comprobar("rst_valor_w", 32'(valor_w), 32'd0);
        comprobar("rst_en_min_w", 32'(en_min_w), 32'd1);
        comprobar("rst_en_max_w", 32'(en_max_w), 32'd0);
        comprobar("rst_cambio_w", 32'(cambio_w), 32'd0);
        comprobar("rst_valor_s", 32'(valor_s), 32'd0);
`ifdef AJUSTE_CONTADOR_BCD_EN
        comprobar("rst_dec_w", 32'(decenas_w), 32'd0);
        comprobar("rst_uni_w", 32'(unidades_w), 32'd0);
`endif

        // Single up pulse.
        aumentar = 1'b0;
        ciclo();
        comprobar("up1_valor_w", 32'(valor_w), 32'd1);
        comprobar("up1_cambio_w", 32'(cambio_w), 32'd1);
        comprobar("up1_en_min_w", 32'(en_min_w), 32'd0);
        aumentar = 1'b1;
        ciclo();
        comprobar("up1_cambio_off", 32'(cambio_w), 32'd0);
        comprobar("up1_hold", 32'(valor_w), 32'd1);

        // Load 99.
        cargar = 1'b1;
        valor_carga = 7'd99;
        ciclo();
        cargar = 1'b0;
        comprobar("ld99_valor_w", 32'(valor_w), 32'd99);
        comprobar("ld99_en_max_w", 32'(en_max_w), 32'd1);
        comprobar("ld99_cambio_w", 32'(cambio_w), 32'd1);
        ciclo();

        // Up at max: wrap vs saturate.
        aumentar = 1'b0;
        ciclo();
        comprobar("wrap_up_valor_w", 32'(valor_w), 32'd0);
        comprobar("wrap_up_cambio_w", 32'(cambio_w), 32'd1);
        comprobar("sat_up_valor_s", 32'(valor_s), 32'd99);
        comprobar("sat_up_cambio_s", 32'(cambio_s), 32'd0);
        aumentar = 1'b1;
        ciclo();

        // Down: wrap at min vs plain decrement.
        disminuir = 1'b0;
        ciclo();
        comprobar("wrap_dn_valor_w", 32'(valor_w), 32'd99);
        comprobar("wrap_dn_cambio_w", 32'(cambio_w), 32'd1);
        comprobar("dn_valor_s", 32'(valor_s), 32'd98);
        comprobar("dn_cambio_s", 32'(cambio_s), 32'd1);
        disminuir = 1'b1;
        ciclo();

        // Three down pulses at zero in saturate mode.
        cargar = 1'b1;
        valor_carga = 7'd0;
        ciclo();
        cargar = 1'b0;
        ciclo();
        for (int i = 0; i < 3; i++) begin
            disminuir = 1'b0;
            ciclo();
            comprobar("sat_dn_valor_s", 32'(valor_s), 32'd0);
            comprobar("sat_dn_cambio_s", 32'(cambio_s), 32'd0);
            comprobar("sat_dn_en_min_s", 32'(en_min_s), 32'd1);
            disminuir = 1'b1;
            ciclo();
        end
        comprobar("dn3_valor_w", 32'(valor_w), 32'd97);

        // Held-low input steps exactly once.
        cargar = 1'b1;
        valor_carga = 7'd5;
        ciclo();
        cargar = 1'b0;
        ciclo();
        aumentar = 1'b0;
        for (int i = 0; i < 20; i++) begin
            ciclo();
            comprobar("held_valor_s", 32'(valor_s), 32'd6);
        end
        aumentar = 1'b1;
        ciclo();
        comprobar("held_release", 32'(valor_s), 32'd6);

        // Both steps together: no change.
        aumentar = 1'b0;
        disminuir = 1'b0;
        ciclo();
        comprobar("both_valor_s", 32'(valor_s), 32'd6);
        comprobar("both_cambio_s", 32'(cambio_s), 32'd0);
        aumentar = 1'b1;
        disminuir = 1'b1;
        ciclo();

        // Over-range load with simultaneous step: clamp, step discarded.
        cargar = 1'b1;
        valor_carga = 7'd120;
        aumentar = 1'b0;
        ciclo();
        cargar = 1'b0;
        aumentar = 1'b1;
        comprobar("clamp_valor_s", 32'(valor_s), 32'd99);
        comprobar("clamp_en_max_s", 32'(en_max_s), 32'd1);
        comprobar("clamp_valor_w", 32'(valor_w), 32'd99);
        comprobar("clamp_cambio_s", 32'(cambio_s), 32'd1);
        ciclo();

        // Pulse while disabled is lost, not deferred.
        habilitar = 1'b0;
        disminuir = 1'b0;
        ciclo();
        comprobar("dis_valor_s", 32'(valor_s), 32'd99);
        comprobar("dis_cambio_s", 32'(cambio_s), 32'd0);
        disminuir = 1'b1;
        habilitar = 1'b1;
        ciclo();
        comprobar("dis_lost_s", 32'(valor_s), 32'd99);

        // Load of an equal value: no cambio.
        cargar = 1'b1;
        valor_carga = 7'd99;
        ciclo();
        cargar = 1'b0;
        comprobar("eq_ld_cambio_s", 32'(cambio_s), 32'd0);

        // Load 47, digits trail by one cycle.
        cargar = 1'b1;
        valor_carga = 7'd47;
        ciclo();
        cargar = 1'b0;
        comprobar("ld47_valor_w", 32'(valor_w), 32'd47);
`ifdef AJUSTE_CONTADOR_BCD_EN
        comprobar("ld47_dec_lag", 32'(decenas_w), 32'd9);
        comprobar("ld47_uni_lag", 32'(unidades_w), 32'd9);
`endif
        ciclo();
`ifdef AJUSTE_CONTADOR_BCD_EN
        comprobar("ld47_dec", 32'(decenas_w), 32'd4);
        comprobar("ld47_uni", 32'(unidades_w), 32'd7);
`endif

        // Reset overrides a load and a step in the same cycle.
        reset_n = 1'b0;
        cargar = 1'b1;
        valor_carga = 7'd30;
        aumentar = 1'b0;
        ciclo();
        comprobar("mrst_valor_w", 32'(valor_w), 32'd0);
        comprobar("mrst_cambio_w", 32'(cambio_w), 32'd0);
        comprobar("mrst_en_min_w", 32'(en_min_w), 32'd1);
        comprobar("mrst_en_max_w", 32'(en_max_w), 32'd0);
`ifdef AJUSTE_CONTADOR_BCD_EN
        comprobar("mrst_dec_w", 32'(decenas_w), 32'd0);
        comprobar("mrst_uni_w", 32'(unidades_w), 32'd0);
`endif
        reset_n = 1'b1;
        cargar = 1'b0;
        aumentar = 1'b1;
        ciclo();
        comprobar("post_rst_valor_w", 32'(valor_w), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
